// File: rtl/hex_display_ctrl.sv
// N-digit seven-segment display controller: hex, unsigned/signed decimal (sequential
// double-dabble) or blank rendering, with per-digit blink and sticky overflow.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned BLINK_DIV  = 25000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [1:0]              in_mode,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned SEG_W  = 7 * NUM_DIGITS;
    localparam int unsigned PAD_W  = (BCD_W > DATA_W) ? BCD_W : DATA_W;
    localparam int unsigned ITER_W = $clog2(DATA_W);
    localparam int unsigned CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] MODE_HEX   = 2'd0;
    localparam logic [1:0] MODE_UDEC  = 2'd1;
    localparam logic [1:0] MODE_SDEC  = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t state, state_next;
    logic   accept_c;
    logic   last_iter_c;

    logic [1:0]        mode_q;
    logic              sign_q;
    logic [DATA_W-1:0] data_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj_c;
    logic              ovf_q;
    logic [ITER_W-1:0] iter_q;

    logic [PAD_W-1:0]  hex_pad_c;
    logic [SEG_W-1:0]  digit_c;
    logic [SEG_W-1:0]  digit_q;
    logic [SEG_W-1:0]  gated_c;
    logic              dec_ovf_c;
    logic              seen_c;
    logic [3:0]        dnib_c;

    logic [CNT_W-1:0]  blink_cnt;
    logic              blink_phase;

    // Active-high segment pattern, bit0 = a .. bit6 = g.
    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h00;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign last_iter_c = (iter_q == ITER_W'(DATA_W - 1));

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    state_next = ((in_mode == MODE_UDEC) || (in_mode == MODE_SDEC)) ? CONVERT : LOAD;
                end
            end
            CONVERT: begin
                if (last_iter_c) begin
                    state_next = LOAD;
                end
            end
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            in_ready <= (state_next == IDLE);
            busy     <= (state_next == CONVERT);
        end
    end

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            mode_q <= MODE_BLANK;
            sign_q <= 1'b0;
            data_q <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            iter_q <= '0;
        end else if (accept_c) begin
            mode_q <= in_mode;
            sign_q <= (in_mode == MODE_SDEC) && in_data[DATA_W-1];
            data_q <= ((in_mode == MODE_SDEC) && in_data[DATA_W-1]) ? (~in_data + DATA_W'(1)) : in_data;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            iter_q <= '0;
        end else if (state == CONVERT) begin
            bcd_q  <= {bcd_adj_c[BCD_W-2:0], data_q[DATA_W-1]};
            data_q <= {data_q[DATA_W-2:0], 1'b0};
            ovf_q  <= ovf_q | bcd_adj_c[BCD_W-1];
            iter_q <= iter_q + ITER_W'(1);
        end
    end

    assign hex_pad_c = PAD_W'(data_q);

    // Digit codes with leading-zero blanking, sign and overflow substitution.
    always_comb begin
        digit_c   = '0;
        seen_c    = 1'b0;
        dnib_c    = 4'd0;
        dec_ovf_c = ovf_q | ((mode_q == MODE_SDEC) && (bcd_q[BCD_W-1 -: 4] != 4'd0));
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            dnib_c = bcd_q[4*i +: 4];
            seen_c = seen_c | (dnib_c != 4'd0) | (i == 0);
            case (mode_q)
                MODE_HEX: digit_c[7*i +: 7] = hex_font(hex_pad_c[4*i +: 4]);
                MODE_UDEC, MODE_SDEC: begin
                    if (dec_ovf_c) begin
                        digit_c[7*i +: 7] = SEG_E;
                    end else if (seen_c) begin
                        digit_c[7*i +: 7] = hex_font(dnib_c);
                    end
                end
                default: digit_c[7*i +: 7] = 7'h00;
            endcase
        end
        if ((mode_q == MODE_SDEC) && sign_q && !dec_ovf_c) begin
            digit_c[SEG_W-1 -: 7] = SEG_MINUS;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            digit_q  <= '0;
            overflow <= 1'b0;
        end else if (state == LOAD) begin
            digit_q  <= digit_c;
            overflow <= ((mode_q == MODE_UDEC) || (mode_q == MODE_SDEC)) && dec_ovf_c;
        end
    end

    // Free-running blink timebase.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        gated_c = digit_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (blink_phase && blink_mask[i]) begin
                gated_c[7*i +: 7] = 7'h00;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            seg_out <= {SEG_W{ACTIVE_LOW}};
        end else begin
            seg_out <= gated_c ^ {SEG_W{ACTIVE_LOW}};
        end
    end

endmodule
